// File: rtl/muldiv_if.sv
// muldiv_if: bundle of the signals between the ID stage / arithmetic units
// and the multiply/divide scheduler.
//   id_*            : instruction information from ID (driven by master)
//   mul_hi/mul_lo   : multiplier result (driven by master)
//   div_done/q/r    : divider completion pulse and result (driven by master)
//   op_a/op_b/sign  : latched operands to both units (driven by slave)
//   mul/div_start   : one-cycle unit start pulses (driven by slave)
//   hi/lo_wena/wdata: HI/LO write-back (driven by slave)
//   md_stall/busy   : hazard stall and activity status (driven by slave)
//   div_timeout     : sticky divider timeout flag (driven by slave)
interface muldiv_if;
    logic        id_valid;
    logic        id_mul_ena;
    logic        id_div_ena;
    logic        id_mul_sign;
    logic        id_div_sign;
    logic        id_hilo_read;
    logic        id_hilo_write;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_sign;
    logic        mul_start;
    logic        div_start;
    logic        hi_wena;
    logic        lo_wena;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        md_stall;
    logic        busy;
    logic        div_timeout;

    modport master (
        output id_valid, id_mul_ena, id_div_ena, id_mul_sign, id_div_sign,
               id_hilo_read, id_hilo_write, id_rs_data, id_rt_data,
               mul_hi, mul_lo, div_done, div_q, div_r,
        input  op_a, op_b, op_sign, mul_start, div_start, hi_wena, lo_wena,
               hi_wdata, lo_wdata, md_stall, busy, div_timeout
    );

    modport slave (
        input  id_valid, id_mul_ena, id_div_ena, id_mul_sign, id_div_sign,
               id_hilo_read, id_hilo_write, id_rs_data, id_rt_data,
               mul_hi, mul_lo, div_done, div_q, div_r,
        output op_a, op_b, op_sign, mul_start, div_start, hi_wena, lo_wena,
               hi_wdata, lo_wdata, md_stall, busy, div_timeout
    );
endinterface

// File: rtl/muldiv_sched.sv
// muldiv_sched: accepts one mult/multu/div/divu from ID, latches its
// operands, sequences a fixed-latency multiplier or a start/done divider,
// and writes the result to HI/LO in a single write-back cycle. Stalls ID
// instructions touching HI/LO or issuing another mul/div while busy.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   md  - muldiv_if slave modport (ID info, unit results, operands,
//         starts, HI/LO write-back, stall/busy/timeout status)
// Parameters:
//   MUL_LATENCY - multiplier cycles from mul_start to valid result (1..15)
//   DIV_TIMEOUT - maximum DIV-state cycles waiting for div_done (1..255)
module muldiv_sched #(
    parameter int MUL_LATENCY = 2,
    parameter int DIV_TIMEOUT = 63
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave md
);
    localparam logic [7:0]  MUL_LOAD = 8'(MUL_LATENCY - 1);
    localparam logic [7:0]  DIV_LAST = 8'(DIV_TIMEOUT - 1);
    localparam logic [31:0] DZ_LO    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {IDLE, MUL, DIV, WB} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        first, first_nxt;
    logic [31:0] lat_a, lat_a_nxt;
    logic [31:0] lat_b, lat_b_nxt;
    logic        lat_sign, lat_sign_nxt;
    logic [31:0] res_hi, res_hi_nxt;
    logic [31:0] res_lo, res_lo_nxt;
    logic        timeout, timeout_nxt;
    logic        accept_mul, accept_div;

    // Mul has priority when ID raises both enables.
    assign accept_mul = (state == IDLE) && md.id_valid && md.id_mul_ena;
    assign accept_div = (state == IDLE) && md.id_valid && md.id_div_ena && !md.id_mul_ena;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            first    <= 1'b0;
            lat_a    <= '0;
            lat_b    <= '0;
            lat_sign <= 1'b0;
            res_hi   <= '0;
            res_lo   <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            first    <= first_nxt;
            lat_a    <= lat_a_nxt;
            lat_b    <= lat_b_nxt;
            lat_sign <= lat_sign_nxt;
            res_hi   <= res_hi_nxt;
            res_lo   <= res_lo_nxt;
            timeout  <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        first_nxt    = 1'b0;
        lat_a_nxt    = lat_a;
        lat_b_nxt    = lat_b;
        lat_sign_nxt = lat_sign;
        res_hi_nxt   = res_hi;
        res_lo_nxt   = res_lo;
        timeout_nxt  = timeout;

        case (state)
            IDLE: begin
                if (accept_mul) begin
                    lat_a_nxt    = md.id_rs_data;
                    lat_b_nxt    = md.id_rt_data;
                    lat_sign_nxt = md.id_mul_sign;
                    cnt_nxt      = MUL_LOAD;
                    first_nxt    = 1'b1;
                    state_nxt    = MUL;
                end else if (accept_div) begin
                    lat_a_nxt    = md.id_rs_data;
                    lat_b_nxt    = md.id_rt_data;
                    lat_sign_nxt = md.id_div_sign;
                    if (md.id_rt_data == 32'd0) begin
                        // Divide by zero never reaches the divider.
                        res_hi_nxt = md.id_rs_data;
                        res_lo_nxt = DZ_LO;
                        state_nxt  = WB;
                    end else begin
                        cnt_nxt   = 8'd0;
                        first_nxt = 1'b1;
                        state_nxt = DIV;
                    end
                end
            end
            MUL: begin
                if (cnt == 8'd0) begin
                    res_hi_nxt = md.mul_hi;
                    res_lo_nxt = md.mul_lo;
                    state_nxt  = WB;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            DIV: begin
                // A done pulse in the last allowed cycle still wins over timeout.
                if (md.div_done) begin
                    res_hi_nxt = md.div_r;
                    res_lo_nxt = md.div_q;
                    state_nxt  = WB;
                end else if (cnt == DIV_LAST) begin
                    res_hi_nxt  = '0;
                    res_lo_nxt  = '0;
                    timeout_nxt = 1'b1;
                    state_nxt   = WB;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            WB: begin
                cnt_nxt   = 8'd0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        md.busy      = (state != IDLE);
        md.mul_start = (state == MUL) && first;
        md.div_start = (state == DIV) && first;
        md.hi_wena   = (state == WB);
        md.lo_wena   = (state == WB);
        md.hi_wdata  = (state == WB) ? res_hi : 32'd0;
        md.lo_wdata  = (state == WB) ? res_lo : 32'd0;
        // Includes WB, so an mfhi behind the op reads the freshly written HI.
        md.md_stall  = (state != IDLE) && md.id_valid &&
                       (md.id_mul_ena || md.id_div_ena ||
                        md.id_hilo_read || md.id_hilo_write);
    end

    assign md.op_a        = lat_a;
    assign md.op_b        = lat_b;
    assign md.op_sign     = lat_sign;
    assign md.div_timeout = timeout;

endmodule

// File: tb/tb_muldiv_sched.sv
`timescale 1ns/1ps
module tb_muldiv_sched;
    localparam int MUL_LAT = 2;
    localparam int DIV_TO  = 63;
    localparam int INF     = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    muldiv_if bus();

    muldiv_sched #(.MUL_LATENCY(MUL_LAT), .DIV_TIMEOUT(DIV_TO)) dut (
        .clk(clk),
        .rst(rst),
        .md (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        logic [63:0] ea, eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    // External multiplier: result only valid MUL_LAT-1 cycles after start.
    int          mul_age = 100;
    logic        mul_valid;
    logic [63:0] mul_p;
    always @(posedge clk) begin
        if (bus.mul_start) mul_age <= 1;
        else if (mul_age < 100) mul_age <= mul_age + 1;
    end
    always_comb begin
        mul_p      = product(bus.op_a, bus.op_b, bus.op_sign);
        mul_valid  = bus.mul_start ? (MUL_LAT == 1) : (mul_age == MUL_LAT - 1);
        bus.mul_hi = mul_valid ? mul_p[63:32] : 32'hDEAD_BEEF;
        bus.mul_lo = mul_valid ? mul_p[31:0]  : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level reference: each accepted op is reduced to its
    // accept cycle, write-back cycle and result values.
    int          m_t = -10, m_wb = -10, m_free = 0, m_kind = 0, m_to_from = INF;
    logic [31:0] m_a = '0, m_b = '0, m_hi = '0, m_lo = '0;
    logic        m_sign = 1'b0;

    always @(negedge clk) begin
        logic        busy_e, wb_e, stall_e;
        logic [63:0] p;
        if (rst) begin
            m_t = -10; m_wb = -10; m_free = 0; m_kind = 0; m_to_from = INF;
            m_a = '0; m_b = '0; m_sign = 1'b0;
        end
        busy_e  = !rst && (cyc > m_t) && (cyc < m_free);
        wb_e    = !rst && (cyc == m_wb);
        stall_e = busy_e && bus.id_valid && (bus.id_mul_ena || bus.id_div_ena ||
                                              bus.id_hilo_read || bus.id_hilo_write);
        chk("busy",        bus.busy,        busy_e);
        chk("md_stall",    bus.md_stall,    stall_e);
        chk("mul_start",   bus.mul_start,   busy_e && m_kind == 1 && cyc == m_t + 1);
        chk("div_start",   bus.div_start,   busy_e && m_kind == 2 && cyc == m_t + 1);
        chk("hi_wena",     bus.hi_wena,     wb_e);
        chk("lo_wena",     bus.lo_wena,     wb_e);
        chk("hi_wdata",    bus.hi_wdata,    wb_e ? m_hi : 32'd0);
        chk("lo_wdata",    bus.lo_wdata,    wb_e ? m_lo : 32'd0);
        chk("op_a",        bus.op_a,        m_a);
        chk("op_b",        bus.op_b,        m_b);
        chk("op_sign",     bus.op_sign,     m_sign);
        chk("div_timeout", bus.div_timeout, !rst && cyc >= m_to_from);
        if (!rst) begin
            if (m_kind == 2 && m_wb == INF && busy_e) begin
                if (bus.div_done) begin
                    m_wb = cyc + 1; m_free = cyc + 2; m_hi = bus.div_r; m_lo = bus.div_q;
                end else if (cyc == m_t + DIV_TO) begin
                    m_wb = cyc + 1; m_free = cyc + 2; m_hi = '0; m_lo = '0;
                    if (m_to_from == INF) m_to_from = cyc + 1;
                end
            end
            if (!busy_e && bus.id_valid && (bus.id_mul_ena || bus.id_div_ena)) begin
                m_t = cyc;
                m_a = bus.id_rs_data;
                m_b = bus.id_rt_data;
                if (bus.id_mul_ena) begin
                    m_kind = 1; m_sign = bus.id_mul_sign;
                    p = product(m_a, m_b, m_sign);
                    m_hi = p[63:32]; m_lo = p[31:0];
                    m_wb = cyc + MUL_LAT + 1; m_free = cyc + MUL_LAT + 2;
                end else if (bus.id_rt_data == 32'd0) begin
                    m_kind = 3; m_sign = bus.id_div_sign;
                    m_hi = m_a; m_lo = 32'hFFFF_FFFF;
                    m_wb = cyc + 1; m_free = cyc + 2;
                end else begin
                    m_kind = 2; m_sign = bus.id_div_sign;
                    m_wb = INF; m_free = INF;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic at(input int c);
        goto(c);
        @(negedge clk);
    endtask

    task automatic clr_id();
        bus.id_valid = 0; bus.id_mul_ena = 0; bus.id_div_ena = 0;
        bus.id_mul_sign = 0; bus.id_div_sign = 0;
        bus.id_hilo_read = 0; bus.id_hilo_write = 0;
        bus.id_rs_data = '0; bus.id_rt_data = '0;
    endtask

    task automatic issue(input logic mul, input logic div, input logic sgn,
                         input logic [31:0] rs, input logic [31:0] rt);
        bus.id_valid = 1; bus.id_mul_ena = mul; bus.id_div_ena = div;
        bus.id_mul_sign = sgn; bus.id_div_sign = sgn;
        bus.id_rs_data = rs; bus.id_rt_data = rt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        clr_id();
        bus.div_done = 0; bus.div_q = '0; bus.div_r = '0;
        step();
        chk("rst_busy",    bus.busy,        1'b0);
        chk("rst_hi_wena", bus.hi_wena,     1'b0);
        chk("rst_op_a",    bus.op_a,        32'd0);
        chk("rst_timeout", bus.div_timeout, 1'b0);
        step();
        rst = 0;
        step();

        // signed mult -3 * 7
        t = cyc;
        issue(1, 0, 1, 32'hFFFF_FFFD, 32'd7);
        step(); clr_id();
        at(t + 1); chk("t1_mul_start", bus.mul_start, 1'b1);
        at(t + 2); chk("t1_mul_start_once", bus.mul_start, 1'b0);
        at(t + 3); chk("t1_hi_wena", bus.hi_wena, 1'b1);
                   chk("t1_hi", bus.hi_wdata, 32'hFFFF_FFFF);
                   chk("t1_lo", bus.lo_wdata, 32'hFFFF_FFEB);
        at(t + 4); chk("t1_idle", bus.busy, 1'b0);

        // divu 100 / 7, divider answers in the fifth DIV cycle
        step(); t = cyc;
        issue(0, 1, 0, 32'd100, 32'd7);
        step(); clr_id();
        at(t + 1); chk("t2_div_start", bus.div_start, 1'b1);
        at(t + 2); chk("t2_div_start_once", bus.div_start, 1'b0);
        goto(t + 5);
        bus.div_done = 1; bus.div_q = 32'd14; bus.div_r = 32'd2;
        at(t + 5); chk("t2_no_wb_yet", bus.hi_wena, 1'b0);
        step(); bus.div_done = 0;
        at(t + 6); chk("t2_wena", bus.lo_wena, 1'b1);
                   chk("t2_hi", bus.hi_wdata, 32'd2);
                   chk("t2_lo", bus.lo_wdata, 32'd14);

        // signed divide by zero
        step(); t = cyc;
        issue(0, 1, 1, 32'h1234_5678, 32'd0);
        step(); clr_id();
        at(t + 1); chk("t3_wena", bus.hi_wena, 1'b1);
                   chk("t3_hi", bus.hi_wdata, 32'h1234_5678);
                   chk("t3_lo", bus.lo_wdata, 32'hFFFF_FFFF);
                   chk("t3_no_div_start", bus.div_start, 1'b0);
        at(t + 2); chk("t3_idle", bus.busy, 1'b0);

        // multu 5*6 followed by mfhi held in ID
        step(); t = cyc;
        issue(1, 0, 0, 32'd5, 32'd6);
        step(); clr_id(); bus.id_valid = 1; bus.id_hilo_read = 1;
        for (int i = 1; i <= 3; i++) begin
            at(t + i); chk("t4_mfhi_stall", bus.md_stall, 1'b1);
        end
        chk("t4_lo", bus.lo_wdata, 32'd30);
        at(t + 4); chk("t4_mfhi_go", bus.md_stall, 1'b0);

        // multu 7*9, then a signed mult -2*4 waiting in ID
        step(); clr_id(); t = cyc;
        issue(1, 0, 0, 32'd7, 32'd9);
        step(); issue(1, 0, 1, 32'hFFFF_FFFE, 32'd4);
        for (int i = 1; i <= 3; i++) begin
            at(t + i); chk("t4_mult_stall", bus.md_stall, 1'b1);
        end
        chk("t4_lo63", bus.lo_wdata, 32'd63);
        at(t + 4); chk("t4_accept_no_stall", bus.md_stall, 1'b0);
        step(); clr_id();
        at(t + 5); chk("t4_op_a_new", bus.op_a, 32'hFFFF_FFFE);
                   chk("t4_op_b_new", bus.op_b, 32'd4);
        at(t + 7); chk("t4_hi2", bus.hi_wdata, 32'hFFFF_FFFF);
                   chk("t4_lo2", bus.lo_wdata, 32'hFFFF_FFF8);

        // divider never answers
        step(); t = cyc;
        issue(0, 1, 0, 32'd9, 32'd3);
        step(); clr_id();
        at(t + 63); chk("t5_no_wb", bus.hi_wena, 1'b0);
                    chk("t5_busy", bus.busy, 1'b1);
        at(t + 64); chk("t5_wb", bus.hi_wena, 1'b1);
                    chk("t5_hi0", bus.hi_wdata, 32'd0);
                    chk("t5_lo0", bus.lo_wdata, 32'd0);
                    chk("t5_timeout", bus.div_timeout, 1'b1);
        step(); t = cyc;
        issue(0, 1, 0, 32'd1, 32'd0);
        step(); clr_id();
        at(t + 2); chk("t5_timeout_sticky", bus.div_timeout, 1'b1);

        // asynchronous reset in the third DIV cycle
        step(); t = cyc;
        issue(0, 1, 1, 32'd50, 32'd5);
        step(); clr_id();
        goto(t + 3);
        #2 rst = 1;
        #1;
        chk("t6_busy", bus.busy, 1'b0);
        chk("t6_op_a", bus.op_a, 32'd0);
        chk("t6_timeout_clr", bus.div_timeout, 1'b0);
        chk("t6_hi_wena", bus.hi_wena, 1'b0);
        goto(t + 4); rst = 0;
        goto(t + 5); bus.div_done = 1; bus.div_q = 32'd10; bus.div_r = 32'd0;
        step(); bus.div_done = 0;
        at(t + 6); chk("t6_no_wb", bus.hi_wena, 1'b0);
                   chk("t6_idle", bus.busy, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Multiply/divide scheduler between the ID stage and the EXE-side multi-cycle arithmetic units of the MIPS pipeline CPU. Accepts one mult/multu/div/divu from ID, latches its operands, sequences a fixed-latency multiplier or a start/done iterative divider, and writes the result into HI/LO in a single write-back cycle. While an operation is in flight it stalls any ID instruction that touches HI/LO or issues another mul/div.

## Interface
Parameters:
- MUL_LATENCY, 2, multiplier cycles from `mul_start` to valid `mul_hi`/`mul_lo` (legal range 1..15)
- DIV_TIMEOUT, 63, maximum DIV-state cycles waiting for `div_done` (legal range 1..255)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID instruction is live (not flushed, not stalled by another hazard)
- id_mul_ena  in  1  ID holds mult/multu
- id_div_ena  in  1  ID holds div/divu
- id_mul_sign  in  1  1 = signed multiply
- id_div_sign  in  1  1 = signed divide
- id_hilo_read  in  1  ID holds mfhi/mflo
- id_hilo_write  in  1  ID holds mthi/mtlo
- id_rs_data  in  32  forwarded rs operand
- id_rt_data  in  32  forwarded rt operand
- mul_hi, mul_lo  in  32 each  multiplier result
- div_done  in  1  divider result valid, single-cycle pulse
- div_q, div_r  in  32 each  divider quotient, remainder
- op_a, op_b  out  32 each  latched operands to both units
- op_sign  out  1  latched signedness
- mul_start  out  1  one-cycle multiplier start
- div_start  out  1  one-cycle divider start
- hi_wena, lo_wena  out  1 each  HI/LO write enables
- hi_wdata, lo_wdata  out  32 each  HI/LO write data
- md_stall  out  1  stall request to IF/ID
- busy  out  1  state != IDLE
- div_timeout  out  1  sticky error flag

## Operation
- States: IDLE, MUL, DIV, WB.
- Accept: in IDLE with `id_valid & (id_mul_ena | id_div_ena)`, latch `op_a=id_rs_data`, `op_b=id_rt_data`, `op_sign` from the matching sign input. If both enables are set, mul wins.
- IDLE -> MUL on mul accept. The cycle counter loads MUL_LATENCY-1. `mul_start=1` in the first MUL cycle only. In the MUL cycle where the counter is 0, capture `res_hi=mul_hi`, `res_lo=mul_lo`, then go to WB.
- IDLE -> DIV on div accept with `id_rt_data != 0`. The counter loads 0. `div_start=1` in the first DIV cycle only. The counter increments each DIV cycle.
  - On `div_done`: capture `res_hi=div_r`, `res_lo=div_q`, then go to WB.
  - If the counter reaches DIV_TIMEOUT-1 without `div_done`: capture hi=lo=0, set `div_timeout`, then go to WB.
- Divide by zero: on accept with `id_rt_data == 0`, go IDLE -> WB directly. Result is hi = rs, lo = 32'hFFFF_FFFF. The divider is never started.
- WB: `hi_wena = lo_wena = 1`, `hi_wdata = res_hi`, `lo_wdata = res_lo`, for exactly one cycle, then IDLE.
- `md_stall = busy & id_valid & (id_mul_ena | id_div_ena | id_hilo_read | id_hilo_write)`. It is also asserted during WB, so mfhi reads the updated HI in the first IDLE cycle.
- The instruction being accepted is never stalled by this block. A new accept is possible only in IDLE, never in the same cycle as WB.
- `div_done` outside DIV is ignored. `id_*` inputs outside IDLE are ignored except for the stall logic.
- An in-flight operation completes regardless of `id_valid` (it is already committed).
- `div_timeout` is cleared only by `rst`.

## Timing
- Reset: state=IDLE, counter=0, and every output is 0 (op_a, op_b, op_sign, starts, enables, wdata, md_stall, busy, div_timeout).
- Mul accepted in cycle T: MUL during T+1..T+MUL_LATENCY, WB at T+MUL_LATENCY+1, IDLE at T+MUL_LATENCY+2.
- Div accepted at T, with `div_done` sampled high in DIV cycle T+k: WB at T+k+1.
- Div by zero accepted at T: WB at T+1.
- `rst` mid-operation: immediate return to IDLE. No WB pulse occurs and the partial result is discarded.
- `op_a`/`op_b`/`op_sign` are stable from the accept edge until the next accept.

## Test plan
- Signed mult, rs=-3, rt=7, MUL_LATENCY=2, mul_hi/lo modelled as 0xFFFFFFFF/0xFFFFFFEB -> mul_start at T+1, one WB at T+3 with hi_wdata=0xFFFFFFFF, lo_wdata=0xFFFFFFEB, busy low at T+4.
- divu 100/7 with divider answering at k=5 -> div_start at T+1 only, WB at T+6 with hi=2, lo=14.
- div rs=0x12345678, rt=0 -> WB at T+1 with hi=0x12345678, lo=0xFFFFFFFF; div_start never asserted.
- mult followed immediately by mfhi, then mult -> md_stall high for T+1..T+3; mfhi proceeds at T+4. A back-to-back mult is likewise stalled until IDLE and is then accepted with new operands.
- Divider never raises div_done, DIV_TIMEOUT=63 -> WB after 63 DIV cycles with hi=lo=0; div_timeout stays 1 until rst.
- rst asserted asynchronously in the third DIV cycle -> all outputs 0 immediately, no WB pulse. A div_done arriving after rst release is ignored.
